// File: rtl/vme_slot_match_pkg.sv
// Shared types and constants for the VME A24 slot matcher.
//   state_e             : matcher FSM states
//   AM_A24_*            : A24 single-cycle address modifier codes accepted
//   BAR_NONE            : base byte meaning "slot unknown"
//   am_is_a24_single()  : true for the four accepted AM codes
package vme_slot_match_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DECODE   = 2'd1,
        SELECTED = 2'd2,
        WAIT_AS  = 2'd3
    } state_e;

    localparam int unsigned AM_W   = 6;
    localparam int unsigned ADDR_W = 23;
    localparam int unsigned OFFS_W = 18;
    localparam int unsigned BAR_W  = 8;

    localparam logic [AM_W-1:0]  AM_A24_NP_DATA  = 6'h39;
    localparam logic [AM_W-1:0]  AM_A24_NP_PROG  = 6'h3A;
    localparam logic [AM_W-1:0]  AM_A24_SUP_DATA = 6'h3D;
    localparam logic [AM_W-1:0]  AM_A24_SUP_PROG = 6'h3E;
    localparam logic [BAR_W-1:0] BAR_NONE        = 8'h00;

    // Block transfers and every non-A24 code fall outside this set.
    function automatic logic am_is_a24_single(input logic [AM_W-1:0] am);
        return (am == AM_A24_NP_DATA)  || (am == AM_A24_NP_PROG) ||
               (am == AM_A24_SUP_DATA) || (am == AM_A24_SUP_PROG);
    endfunction

endpackage

// File: rtl/vme_sync_ff.sv
// N-stage synchronizer for asynchronous active-low VME strobes.
// Resets to 1 so the strobe reads inactive out of reset.
//   clk_i   : destination clock
//   rst_n_i : async active-low reset
//   d_i     : asynchronous input
//   q_o     : synchronized output (last stage)
module vme_sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff_q;
    logic [STAGES-1:0] ff_d;

    // Shift chain: stage 0 captures the raw input.
    always_comb begin
        ff_d = {ff_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ff_q <= '1;
        end else begin
            ff_q <= ff_d;
        end
    end

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/vme_a24_slot_matcher.sv
// Decides once per VME cycle whether an A24 single-cycle access targets this
// board (A[23:19] == bar_i[7:3]) and holds the selection until the local
// slave reports done or the master releases AS*.
// Optional feature: define VME_SLOT_MATCH_TIMEOUT_EN to add a SELECTED
// watchdog that pulses timeout_o after TIMEOUT_CYCLES cycles.
//   clk_i, rst_n_i              : clock, async active-low reset
//   vme_as_n_i                  : async AS*, synchronized internally
//   vme_am_i/addr_i/write_n_i   : VME cycle qualifiers, latched on AS* fall
//   bar_i                       : slot base byte, sampled in DECODE only
//   done_i                      : local slave completion pulse
//   sel_o, addr_o, write_o      : selection and latched cycle attributes
//   miss_o, abort_o, timeout_o  : single-cycle status pulses
module vme_a24_slot_matcher
    import vme_slot_match_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        vme_as_n_i,
    input  logic [5:0]  vme_am_i,
    input  logic [22:0] vme_addr_i,
    input  logic        vme_write_n_i,
    input  logic [7:0]  bar_i,
    input  logic        done_i,
    output logic        sel_o,
    output logic [17:0] addr_o,
    output logic        write_o,
    output logic        miss_o,
    output logic        abort_o,
    output logic        timeout_o
);

    logic as_s;

    vme_sync_ff #(.STAGES(SYNC_STAGES)) u_as_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (vme_as_n_i),
        .q_o     (as_s)
    );

    state_e            state_q, state_d;
    logic              as_prev_q, as_prev_d;
    logic [ADDR_W-1:0] addr_lat_q, addr_lat_d;
    logic [AM_W-1:0]   am_q, am_d;
    logic              wr_q, wr_d;
    logic              sel_q, sel_d;
    logic              miss_q, miss_d;
    logic              abort_q, abort_d;
    logic              timeout_q, timeout_d;
    logic              as_fall;
    logic              hit;
    logic              unused_bits;

`ifdef VME_SLOT_MATCH_TIMEOUT_EN
    localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign unused_bits = ^bar_i[2:0];
`else
    assign unused_bits = ^{bar_i[2:0], 32'(TIMEOUT_CYCLES)};
`endif

    assign as_fall = as_prev_q && !as_s;
    assign hit     = (addr_lat_q[ADDR_W-1:OFFS_W] == bar_i[7:3]) &&
                     (bar_i != BAR_NONE) && am_is_a24_single(am_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        as_prev_d  = as_s;
        addr_lat_d = addr_lat_q;
        am_d       = am_q;
        wr_d       = wr_q;
        miss_d     = 1'b0;
        abort_d    = 1'b0;
        timeout_d  = 1'b0;
`ifdef VME_SLOT_MATCH_TIMEOUT_EN
        cnt_d      = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (as_fall) begin
                    addr_lat_d = vme_addr_i;
                    am_d       = vme_am_i;
                    wr_d       = !vme_write_n_i;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                if (hit) begin
                    state_d = SELECTED;
                end else begin
                    miss_d  = 1'b1;
                    state_d = WAIT_AS;
                end
            end
            SELECTED: begin
`ifdef VME_SLOT_MATCH_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                // done_i has priority over both AS* release and timeout.
                if (done_i) begin
                    state_d = WAIT_AS;
                end else if (as_s) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end
`ifdef VME_SLOT_MATCH_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = WAIT_AS;
                end
`endif
            end
            WAIT_AS: begin
                if (as_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        sel_d = (state_d == SELECTED);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            as_prev_q  <= 1'b1;
            addr_lat_q <= '0;
            am_q       <= '0;
            wr_q       <= 1'b0;
            sel_q      <= 1'b0;
            miss_q     <= 1'b0;
            abort_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            as_prev_q  <= as_prev_d;
            addr_lat_q <= addr_lat_d;
            am_q       <= am_d;
            wr_q       <= wr_d;
            sel_q      <= sel_d;
            miss_q     <= miss_d;
            abort_q    <= abort_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef VME_SLOT_MATCH_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign sel_o     = sel_q;
    assign addr_o    = addr_lat_q[OFFS_W-1:0];
    assign write_o   = wr_q;
    assign miss_o    = miss_q;
    assign abort_o   = abort_q;
    assign timeout_o = timeout_q;

endmodule
